ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit data RAM between two requesters: port A (stack CPU, primary) and port B (secondary master, e.g. loader or debug/segment scanner).
- Fixed priority to A, with a starvation guard that forces a B grant after B has waited MAX_WAIT cycles.
- At most one access is issued per cycle; reads return in order after a fixed RAM latency.
- Sits between the masters and the RAM address/data/wren/q pins.

Parameters:
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 2, cycles from ram_address driven to ram_q valid (1..4)
- MAX_WAIT, 4, consecutive cycles B may be denied before a forced grant (1..15)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- a_req  in  1  port A access request, held until a_gnt
- a_we  in  1  A write (1) / read (0)
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A request accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid pulse
- a_rdata  out  DW  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for B
- ram_address  out  AW  to RAM
- ram_wren  out  1  to RAM
- ram_data  out  DW  to RAM
- ram_q  in  DW  from RAM
- starve_cnt  out  4  current B wait count (debug dump)

Behaviour:
- Reset values: ram_address=0, ram_data=0, ram_wren=0, starve_cnt=0, a_rvalid=b_rvalid=0, a_gnt=b_gnt=0 while reset is high, return pipeline cleared.
- Grant (cycle t, combinational):
  - force_b = (starve_cnt >= MAX_WAIT) & b_req.
  - a_gnt = a_req & !force_b.
  - b_gnt = b_req & (!a_req | force_b).
  - Never both high.
- Issue: at the edge ending cycle t, the winner's addr/wdata/we are registered onto ram_address/ram_data/ram_wren, so the RAM sees the access in cycle t+1.
- No grant: ram_wren <= 0. ram_address and ram_data hold their previous values.
- Write: completes on grant; no rvalid.
- Read: a tag {valid, port} enters an RD_LAT-deep shift register.
  - The matching x_rvalid pulses for exactly one cycle, in cycle t+1+RD_LAT.
  - x_rdata = ram_q (pass-through) in that cycle.
  - a_rdata and b_rdata both mirror ram_q; consumers qualify with rvalid.
- Reads return strictly in issue order. Back-to-back reads every cycle give one rvalid per cycle.
- Read-after-write to the same address in consecutive grants returns the new data, because RAM ordering holds.
- starve_cnt:
  - reset to 0 on any b_gnt, or when b_req=0;
  - +1 when b_req=1 & b_gnt=0;
  - saturates at 15.
- Forced grant: while force_b is active, A sees a_gnt=0 and must keep a_req, a_we, a_addr and a_wdata stable. A is re-granted the following cycle if B drops its request.
- Requester rule: x_req, x_we, x_addr and x_wdata must be stable from assertion until x_gnt. A master may re-assert x_req in the cycle after its grant.
- Reset mid-operation: in-flight read tags are discarded and no rvalid follows. A write registered before reset is not retracted, but ram_wren drops in the cycle after reset.

Test Plan:
- Write phase: A only, writes 0x0010<-0x1234 then 0x0011<-0xBEEF on back-to-back grants.
  - Read phase: A reads 0x0010.
  - Required: a_gnt each request cycle; ram_wren=1 in cycles t+1 and t+2.
  - Required: the read gives a_rvalid in cycle t+3 with a_rdata=0x1234 (RD_LAT=2).
- Simultaneous a_req and b_req reads, starve_cnt=0 → A is granted; B waits and starve_cnt increments to 1.
- A requests continuously while B requests continuously with MAX_WAIT=4 → B is granted on its 5th request cycle, a_gnt is 0 in that cycle, and starve_cnt returns to 0.
- Interleaved reads A@0x0010, B@0x0011, A@0x0010 on consecutive cycles → a_rvalid, b_rvalid, a_rvalid on consecutive cycles with data 0x1234, 0xBEEF, 0x1234.
- B write 0x0020<-0x00FF, then B read 0x0020 in the next cycle → b_rvalid with 0x00FF, and no a_rvalid.
- Reset asserted one cycle after an A read grant → no a_rvalid appears, all outputs show reset values, and the next request after reset is served normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Master/RAM-side signal bundle for ram_port_arbiter: two requester ports plus the RAM pins.
// "slave" is the arbiter's view; "master" is the view of the masters and RAM driving it.
interface ram_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_gnt;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;

   logic [AW-1:0] ram_address;
   logic          ram_wren;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] ram_q;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  ram_q,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output ram_address, ram_wren, ram_data
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output ram_q,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  ram_address, ram_wren, ram_data
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for a single-port RAM: fixed priority to A, with a starvation guard
// that forces a B grant after MAX_WAIT denied cycles. Read data returns in issue order.
module ram_port_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                clock,
   input  logic                reset,
   ram_port_arbiter_if.slave   bus,
   output logic [3:0]          starve_cnt
);
   logic [3:0]        starve_q, starve_d;
   logic              force_b, a_gnt, b_gnt;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     data_q, data_d;
   logic              wren_q, wren_d;
   logic              iss_vld_q, iss_vld_d;
   logic              iss_port_q, iss_port_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0] tag_port_q, tag_port_d;

   assign force_b = (starve_q >= 4'(MAX_WAIT)) & bus.b_req;
   assign a_gnt   = bus.a_req & ~force_b & ~reset;
   assign b_gnt   = bus.b_req & (~bus.a_req | force_b) & ~reset;

   always_comb begin
      addr_d     = addr_q;
      data_d     = data_q;
      wren_d     = 1'b0;
      iss_vld_d  = 1'b0;
      iss_port_d = 1'b0;
      if (a_gnt) begin
         addr_d    = bus.a_addr;
         data_d    = bus.a_wdata;
         wren_d    = bus.a_we;
         iss_vld_d = ~bus.a_we;
      end else if (b_gnt) begin
         addr_d     = bus.b_addr;
         data_d     = bus.b_wdata;
         wren_d     = bus.b_we;
         iss_vld_d  = ~bus.b_we;
         iss_port_d = 1'b1;
      end
   end

   always_comb begin
      if (!bus.b_req || b_gnt) begin
         starve_d = '0;
      end else if (starve_q != 4'hF) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // The tag rides with the access on the RAM pins for one cycle, then ages RD_LAT stages
   // so that its last stage lines up with ram_q for that access.
   always_comb begin
      tag_vld_d     = '0;
      tag_port_d    = '0;
      tag_vld_d[0]  = iss_vld_q;
      tag_port_d[0] = iss_port_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_port_d[i] = tag_port_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q   <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         iss_vld_q  <= 1'b0;
         iss_port_q <= 1'b0;
         tag_vld_q  <= '0;
         tag_port_q <= '0;
      end else begin
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wren_q     <= wren_d;
         iss_vld_q  <= iss_vld_d;
         iss_port_q <= iss_port_d;
         tag_vld_q  <= tag_vld_d;
         tag_port_q <= tag_port_d;
      end
   end

   assign bus.a_gnt       = a_gnt;
   assign bus.b_gnt       = b_gnt;
   assign bus.a_rvalid    = tag_vld_q[RD_LAT-1] & ~tag_port_q[RD_LAT-1] & ~reset;
   assign bus.b_rvalid    = tag_vld_q[RD_LAT-1] &  tag_port_q[RD_LAT-1] & ~reset;
   assign bus.a_rdata     = bus.ram_q;
   assign bus.b_rdata     = bus.ram_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_data    = data_q;
   assign bus.ram_wren    = wren_q;
   assign starve_cnt      = starve_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus a randomized run checked against a
// grant/scoreboard model; a small RAM model with RD_LAT read latency sits on the RAM pins.
module tb_ram_port_arbiter;
   localparam int AW       = 16;
   localparam int DW       = 16;
   localparam int RD_LAT   = 2;
   localparam int MAX_WAIT = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] starve_cnt;
   int         checks = 0;
   int         errors = 0;

   ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .starve_cnt (starve_cnt)
   );

   always #5 clock = ~clock;

   // RAM model: write on the edge, read data appears RD_LAT cycles after the address.
   logic [DW-1:0] mem    [256];
   logic [DW-1:0] q_pipe [RD_LAT];
   always @(posedge clock) begin
      if (bus.ram_wren) mem[bus.ram_address[7:0]] <= bus.ram_data;
      q_pipe[0] <= mem[bus.ram_address[7:0]];
      for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign bus.ram_q = q_pipe[RD_LAT-1];

   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
   endtask

   task automatic idle(input int n);
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      repeat (n) next_cycle();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      set_a(1'b1, 1'b0, 16'h0010, '0);
      set_b(1'b1, 1'b0, 16'h0011, '0);
      @(negedge clock);
      checks++; if (bus.a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %b want 0", bus.a_gnt); end
      checks++; if (bus.b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt: got %b want 0", bus.b_gnt); end
      next_cycle();
      @(negedge clock);
      checks++; if (bus.ram_address !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0000", bus.ram_address); end
      checks++; if (bus.ram_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", bus.ram_data); end
      checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", bus.ram_wren); end
      checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL rst_starve: got %0d want 0", starve_cnt); end
      checks++; if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.a_rvalid, bus.b_rvalid); end
      next_cycle();
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_write_read;
      set_a(1'b1, 1'b1, 16'h0010, 16'h1234);
      @(negedge clock);
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL wr0_gnt: got %b want 1", bus.a_gnt); end
      next_cycle();
      set_a(1'b1, 1'b1, 16'h0011, 16'hBEEF);
      @(negedge clock);
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL wr1_gnt: got %b want 1", bus.a_gnt); end
      checks++; if ({bus.ram_wren, bus.ram_address, bus.ram_data} !== {1'b1, 16'h0010, 16'h1234}) begin
         errors++; $display("FAIL wr0_pins: got wren=%b addr=%h data=%h want 1/0010/1234", bus.ram_wren, bus.ram_address, bus.ram_data); end
      next_cycle();
      set_a(1'b1, 1'b0, 16'h0010, '0);
      @(negedge clock);
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", bus.a_gnt); end
      checks++; if ({bus.ram_wren, bus.ram_address, bus.ram_data} !== {1'b1, 16'h0011, 16'hBEEF}) begin
         errors++; $display("FAIL wr1_pins: got wren=%b addr=%h data=%h want 1/0011/BEEF", bus.ram_wren, bus.ram_address, bus.ram_data); end
      next_cycle();
      set_a(1'b0, 1'b0, '0, '0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k == 1) begin
            checks++; if ({bus.ram_wren, bus.ram_address} !== {1'b0, 16'h0010}) begin
               errors++; $display("FAIL rd_pins: got wren=%b addr=%h want 0/0010", bus.ram_wren, bus.ram_address); end
         end
         checks++; if (bus.a_rvalid !== (k == 3)) begin errors++; $display("FAIL rd_rvalid_t%0d: got %b want %b", k, bus.a_rvalid, (k == 3)); end
         if (k == 3) begin
            checks++; if (bus.a_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h want 1234", bus.a_rdata); end
         end
         next_cycle();
      end
      idle(3);
   endtask

   task automatic test_priority;
      set_a(1'b1, 1'b0, 16'h0010, '0);
      set_b(1'b1, 1'b0, 16'h0011, '0);
      @(negedge clock);
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin errors++; $display("FAIL prio_gnt: got a=%b b=%b want a=1 b=0", bus.a_gnt, bus.b_gnt); end
      checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL prio_starve0: got %0d want 0", starve_cnt); end
      next_cycle();
      set_a(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++; if (starve_cnt !== 4'd1) begin errors++; $display("FAIL prio_starve1: got %0d want 1", starve_cnt); end
      checks++; if (bus.b_gnt !== 1'b1) begin errors++; $display("FAIL prio_b_gnt: got %b want 1", bus.b_gnt); end
      next_cycle();
      idle(5);
   endtask

   task automatic test_starvation;
      logic exp_b;
      set_a(1'b1, 1'b0, 16'h0010, '0);
      set_b(1'b1, 1'b0, 16'h0011, '0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         exp_b = (k == 5);
         checks++; if (bus.a_gnt !== ~exp_b) begin errors++; $display("FAIL starve_a_gnt_%0d: got %b want %b", k, bus.a_gnt, ~exp_b); end
         checks++; if (bus.b_gnt !== exp_b) begin errors++; $display("FAIL starve_b_gnt_%0d: got %b want %b", k, bus.b_gnt, exp_b); end
         checks++; if (starve_cnt !== 4'(k - 1)) begin errors++; $display("FAIL starve_cnt_%0d: got %0d want %0d", k, starve_cnt, k - 1); end
         next_cycle();
      end
      set_b(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", starve_cnt); end
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL starve_a_regrant: got %b want 1", bus.a_gnt); end
      next_cycle();
      idle(5);
   endtask

   task automatic test_interleave;
      logic [DW-1:0] exp_d;
      for (int k = 0; k < 6; k++) begin
         set_a(k == 0 || k == 2, 1'b0, 16'h0010, '0);
         set_b(k == 1, 1'b0, 16'h0011, '0);
         @(negedge clock);
         exp_d = (k == 4) ? 16'hBEEF : 16'h1234;
         checks++; if (bus.a_rvalid !== (k == 3 || k == 5)) begin errors++; $display("FAIL il_a_rvalid_%0d: got %b want %b", k, bus.a_rvalid, (k == 3 || k == 5)); end
         checks++; if (bus.b_rvalid !== (k == 4)) begin errors++; $display("FAIL il_b_rvalid_%0d: got %b want %b", k, bus.b_rvalid, (k == 4)); end
         if (k >= 3) begin
            checks++; if (bus.ram_q !== exp_d) begin errors++; $display("FAIL il_data_%0d: got %h want %h", k, bus.ram_q, exp_d); end
         end
         next_cycle();
      end
      idle(3);
   endtask

   task automatic test_b_write_read;
      for (int k = 0; k < 6; k++) begin
         set_b(k < 2, k == 0, 16'h0020, 16'h00FF);
         @(negedge clock);
         if (k == 1) begin
            checks++; if ({bus.ram_wren, bus.ram_address} !== {1'b1, 16'h0020}) begin
               errors++; $display("FAIL bw_pins: got wren=%b addr=%h want 1/0020", bus.ram_wren, bus.ram_address); end
         end
         checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL bw_a_rvalid_%0d: got %b want 0", k, bus.a_rvalid); end
         checks++; if (bus.b_rvalid !== (k == 4)) begin errors++; $display("FAIL bw_b_rvalid_%0d: got %b want %b", k, bus.b_rvalid, (k == 4)); end
         if (k == 4) begin
            checks++; if (bus.b_rdata !== 16'h00FF) begin errors++; $display("FAIL bw_data: got %h want 00FF", bus.b_rdata); end
         end
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_reset_midop;
      set_a(1'b1, 1'b0, 16'h0011, '0);
      @(negedge clock);
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", bus.a_gnt); end
      next_cycle();
      set_a(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      for (int k = 2; k < 10; k++) begin
         set_a(k == 6, 1'b0, 16'h0010, '0);
         @(negedge clock);
         if (k == 2) begin
            checks++; if ({bus.ram_wren, bus.ram_address, bus.ram_data, starve_cnt} !== {1'b0, 16'h0, 16'h0, 4'd0}) begin
               errors++; $display("FAIL rm_state: got wren=%b addr=%h data=%h starve=%0d want 0/0000/0000/0", bus.ram_wren, bus.ram_address, bus.ram_data, starve_cnt); end
         end
         if (k == 6) begin
            checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rm_regrant: got %b want 1", bus.a_gnt); end
         end
         checks++; if (bus.a_rvalid !== (k == 9)) begin errors++; $display("FAIL rm_rvalid_%0d: got %b want %b", k, bus.a_rvalid, (k == 9)); end
         if (k == 9) begin
            checks++; if (bus.a_rdata !== 16'h1234) begin errors++; $display("FAIL rm_data: got %h want 1234", bus.a_rdata); end
         end
         next_cycle();
      end
      idle(3);
   endtask

   typedef struct {
      int            due;
      bit            port;
      logic [DW-1:0] data;
   } ret_t;

   task automatic test_random;
      localparam int NR = 400;
      logic          a_pend, b_pend, a_w, b_w, ef, ea, eb, exp_av, exp_bv;
      logic [2:0]    a_ix, b_ix;
      logic [DW-1:0] a_d, b_d;
      logic [DW-1:0] m_mem [8];
      int            m_starve;
      ret_t          rq [$];
      m_starve = 0; a_pend = 0; b_pend = 0;
      a_w = 0; b_w = 0; a_ix = '0; b_ix = '0; a_d = '0; b_d = '0;
      for (int i = 0; i < NR + 16; i++) begin
         if (i < 8) begin
            a_pend = 1; a_w = 1; a_ix = 3'(i); a_d = 16'($urandom);
         end else if (i < NR) begin
            if (!a_pend && $urandom_range(99) < 60) begin
               a_pend = 1; a_w = 1'($urandom_range(1)); a_ix = 3'($urandom_range(7)); a_d = 16'($urandom);
            end
            if (!b_pend && $urandom_range(99) < 50) begin
               b_pend = 1; b_w = 1'($urandom_range(1)); b_ix = 3'($urandom_range(7)); b_d = 16'($urandom);
            end
         end
         set_a(a_pend, a_w, {13'h0008, a_ix}, a_d);
         set_b(b_pend, b_w, {13'h0008, b_ix}, b_d);
         @(negedge clock);
         ef = (m_starve >= MAX_WAIT) && b_pend;
         ea = a_pend && !ef;
         eb = b_pend && (!a_pend || ef);
         exp_av = (rq.size() > 0) && (rq[0].due == i) && !rq[0].port;
         exp_bv = (rq.size() > 0) && (rq[0].due == i) &&  rq[0].port;
         checks++; if ({bus.a_gnt, bus.b_gnt} !== {ea, eb}) begin errors++; $display("FAIL rnd_gnt@%0d: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, ea, eb); end
         checks++; if (starve_cnt !== 4'(m_starve)) begin errors++; $display("FAIL rnd_starve@%0d: got %0d want %0d", i, starve_cnt, m_starve); end
         checks++; if ({bus.a_rvalid, bus.b_rvalid} !== {exp_av, exp_bv}) begin errors++; $display("FAIL rnd_rvalid@%0d: got a=%b b=%b want a=%b b=%b", i, bus.a_rvalid, bus.b_rvalid, exp_av, exp_bv); end
         if (exp_av) begin
            checks++; if (bus.a_rdata !== rq[0].data) begin errors++; $display("FAIL rnd_a_rdata@%0d: got %h want %h", i, bus.a_rdata, rq[0].data); end
         end
         if (exp_bv) begin
            checks++; if (bus.b_rdata !== rq[0].data) begin errors++; $display("FAIL rnd_b_rdata@%0d: got %h want %h", i, bus.b_rdata, rq[0].data); end
         end
         if (rq.size() > 0 && rq[0].due == i) void'(rq.pop_front());
         if (ea) begin
            if (a_w) m_mem[a_ix] = a_d;
            else     rq.push_back('{due: i + 1 + RD_LAT, port: 1'b0, data: m_mem[a_ix]});
            a_pend = 0;
         end
         if (eb) begin
            if (b_w) m_mem[b_ix] = b_d;
            else     rq.push_back('{due: i + 1 + RD_LAT, port: 1'b1, data: m_mem[b_ix]});
            b_pend = 0;
         end
         if (!b_pend || eb) m_starve = 0;
         else if (m_starve < 15) m_starve++;
         next_cycle();
      end
      checks++; if (rq.size() != 0 || a_pend || b_pend) begin errors++; $display("FAIL rnd_drain: got %0d reads outstanding, pend a=%b b=%b, want none", rq.size(), a_pend, b_pend); end
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      test_reset();
      test_write_read();
      test_priority();
      test_starvation();
      test_interleave();
      test_b_write_read();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
